// File: rtl/burst_rd_responder_pkg.sv
// Shared types, widths and helpers for burst_rd_responder and its RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a. Ports: none.
`include "hyper_para.v"

package burst_rd_responder_pkg;

  localparam int DATA_W     = `DATA_WIDTH;
  localparam int ADDR_W     = `ADDR_SIZE;
  localparam int LEN_W      = `LEN_WIDTH;
  // One extra bit so the maximum length loads and counts down without overflow.
  localparam int CNT_W      = `LEN_WIDTH + 1;
  localparam int BYTE_SHIFT = $clog2(`DATA_WIDTH / 8);
  localparam int SUM_W      = `ADDR_SIZE + 2;

  // One entry of the read-return pipeline, travelling alongside the RAM read.
  typedef struct packed {
    logic vld;   // a RAM read was issued for this slot
    logic zero;  // return zero instead of RAM data (out-of-range burst)
  } rd_stage_t;

  // Byte address to word index.
  function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] byte_addr);
    return byte_addr >> BYTE_SHIFT;
  endfunction

  // True when a burst starting at word 'word' of length 'len' runs past 'depth' words.
  function automatic logic burst_oob(input logic [ADDR_W-1:0] word,
                                     input logic [LEN_W-1:0]  len,
                                     input int                depth);
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] lim;
    sum = {2'b00, word} + {{(SUM_W-LEN_W){1'b0}}, len};
    lim = SUM_W'(depth);
    return sum > lim;
  endfunction

endpackage

// File: rtl/burst_rd_mem.sv
// Simple dual-port synchronous RAM: one write port, one read port, read-first.
// Latency: rd_data valid one clock after rd_en/rd_addr are sampled.
// Backpressure: none; a write and a read may occur every cycle.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request; rd_data registered read word.
`include "hyper_para.v"

module burst_rd_mem
  import burst_rd_responder_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = DATA_W
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:DEPTH-1];

  // Both accesses use non-blocking updates, so a same-cycle read of the word
  // being written returns the value held before the write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/hyper_para.v
// Shared width and state-encoding definitions for the burst read path.
// Included by every file that needs bus widths; guarded so repeated includes are harmless.
// Port summary: none (macro definitions only).
`ifndef HYPER_PARA_V
`define HYPER_PARA_V

`define DATA_WIDTH 64
`define ADDR_SIZE  32
`define LEN_WIDTH  8

`define RD_ST_IDLE 2'd0
`define RD_ST_READ 2'd1
`define RD_ST_FIN  2'd2
`define RD_ST_GAP  2'd3

`endif

// File: rtl/burst_rd_responder.sv
// Burst read responder: accepts a held read request, streams len words from on-chip RAM, pulses finish.
// Latency: request accepted at edge T -> data valid T+2..T+1+len, finish at T+2+len (T+1 for len=0).
// Backpressure: none; the initiator holds rd_burst_req until finish, a one-cycle GAP prevents re-acceptance.
// Ports: s_clk/s_rst (sync, active-high); rd_burst_req/addr/len request; rd_burst_data/valid/finish
// response; ld_wr_en/addr/data preload write port usable in any state.
// Optional macro RD_BURST_ADDR_CHK_EN adds rd_burst_err: bursts running past MEM_DEPTH return zero
// words (same timing) and set a sticky error until s_rst. Without it, word addresses wrap.
`include "hyper_para.v"

module burst_rd_responder
  import burst_rd_responder_pkg::*;
#(
  parameter int MEM_DEPTH = 4096,
  parameter int MEM_AW    = $clog2(MEM_DEPTH)
) (
  input  logic                   s_clk,
  input  logic                   s_rst,
  input  logic                   rd_burst_req,
  input  logic [`ADDR_SIZE-1:0]  rd_burst_addr,
  input  logic [`LEN_WIDTH-1:0]  rd_burst_len,
  output logic [`DATA_WIDTH-1:0] rd_burst_data,
  output logic                   rd_burst_valid,
  output logic                   rd_burst_finish,
  input  logic                   ld_wr_en,
  input  logic [MEM_AW-1:0]      ld_wr_addr,
  input  logic [`DATA_WIDTH-1:0] ld_wr_data
`ifdef RD_BURST_ADDR_CHK_EN
  ,
  output logic                   rd_burst_err
`endif
);

  localparam logic [1:0] IDLE = `RD_ST_IDLE;
  localparam logic [1:0] READ = `RD_ST_READ;
  localparam logic [1:0] FIN  = `RD_ST_FIN;
  localparam logic [1:0] GAP  = `RD_ST_GAP;

  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [MEM_AW-1:0] PTR_ONE = MEM_AW'(1);

  logic [1:0]             state;
  logic [MEM_AW-1:0]      ptr;         // next word to read; wraps naturally at MEM_DEPTH
  logic [CNT_W-1:0]       cnt;         // reads still to issue
  logic                   zero_burst;  // current burst returns zeros
  logic [ADDR_W-1:0]      start_word;
  logic                   oob;
  logic                   rd_en;
  logic [DATA_W-1:0]      mem_q;
  rd_stage_t              s1;

  assign start_word = word_index(rd_burst_addr);

`ifdef RD_BURST_ADDR_CHK_EN
  assign oob = burst_oob(start_word, rd_burst_len, MEM_DEPTH);
`else
  // Upper word-index bits are dropped on purpose: the address wraps modulo MEM_DEPTH.
  logic unused_word_hi;
  assign unused_word_hi = ^start_word[ADDR_W-1:MEM_AW];
  assign oob            = 1'b0;
`endif

  // READ lingers one extra cycle after the last issue (cnt == 0) so that
  // finish lands exactly one cycle after the last valid word.
  assign rd_en = (state == READ) && (cnt != '0);

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      zero_burst <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_burst_req) begin
            ptr        <= start_word[MEM_AW-1:0];
            cnt        <= {1'b0, rd_burst_len};
            zero_burst <= oob;
            state      <= (rd_burst_len == '0) ? FIN : READ;
          end
        end
        READ: begin
          if (cnt != '0) begin
            ptr <= ptr + PTR_ONE;
            cnt <= cnt - CNT_ONE;
          end else begin
            state <= FIN;
          end
        end
        FIN:     state <= GAP;
        GAP:     state <= IDLE;   // request is ignored here; it is still held from the last burst
        default: state <= IDLE;
      endcase
    end
  end

  burst_rd_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (MEM_AW),
    .DW    (DATA_W)
  ) u_mem (
    .clk     (s_clk),
    .wr_en   (ld_wr_en),
    .wr_addr (ld_wr_addr),
    .wr_data (ld_wr_data),
    .rd_en   (rd_en),
    .rd_addr (ptr),
    .rd_data (mem_q)
  );

  // s1 tracks the read sitting in the RAM output register; the output stage
  // then registers data, forcing zero whenever the slot is empty or suppressed.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      s1              <= '0;
      rd_burst_valid  <= 1'b0;
      rd_burst_data   <= '0;
      rd_burst_finish <= 1'b0;
    end else begin
      s1.vld          <= rd_en;
      s1.zero         <= zero_burst;
      rd_burst_valid  <= s1.vld;
      rd_burst_data   <= (s1.vld && !s1.zero) ? mem_q : '0;
      rd_burst_finish <= (state == FIN);
    end
  end

`ifdef RD_BURST_ADDR_CHK_EN
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      rd_burst_err <= 1'b0;
    end else if ((state == IDLE) && rd_burst_req && oob) begin
      rd_burst_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_burst_rd_responder.sv
module tb_burst_rd_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic [7:0]  len;
  logic [63:0] data;
  logic        valid;
  logic        finish;
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [63:0] ld_data;
`ifdef RD_BURST_ADDR_CHK_EN
  logic        err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // per-burst observations
  int          vcnt, first_vk, last_vk, fcnt, fk0, fk1, bad_idle;
  logic [63:0] vw [0:299];

  always #5 clk = ~clk;

  burst_rd_responder #(.MEM_DEPTH(4096), .MEM_AW(12)) dut (
    .s_clk           (clk),
    .s_rst           (rst),
    .rd_burst_req    (req),
    .rd_burst_addr   (addr),
    .rd_burst_len    (len),
    .rd_burst_data   (data),
    .rd_burst_valid  (valid),
    .rd_burst_finish (finish),
    .ld_wr_en        (ld_en),
    .ld_wr_addr      (ld_addr),
    .ld_wr_data      (ld_data)
`ifdef RD_BURST_ADDR_CHK_EN
    ,
    .rd_burst_err    (err)
`endif
  );

  // Drives a request at edge k=0 and samples k=0..n at the negedge after each edge.
  // Optional mid-run actions: address/len change, request drop, preload write, reset.
  task automatic run_burst(input logic [31:0] a, input logic [7:0] l,
                           input int sw_k, input logic [31:0] a2, input logic [7:0] l2,
                           input int drop_k, input int ld_k, input logic [11:0] lda,
                           input logic [63:0] ldd, input int rst_k, input int n);
    vcnt = 0; fcnt = 0; first_vk = -1; last_vk = -1; fk0 = -1; fk1 = -1; bad_idle = 0;
    @(negedge clk);
    req = 1'b1; addr = a; len = l;
    for (int k = 0; k <= n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid === 1'b1) begin
        if (vcnt < 300) vw[vcnt] = data;
        if (first_vk < 0) first_vk = k;
        last_vk = k;
        vcnt++;
      end else if (data !== 64'd0) begin
        bad_idle++;
      end
      if (finish === 1'b1) begin
        if (fcnt == 0) fk0 = k; else if (fcnt == 1) fk1 = k;
        fcnt++;
      end
      if (k == sw_k) begin addr = a2; len = l2; end
      if (k == drop_k) req = 1'b0;
      if (k == ld_k) begin ld_en = 1'b1; ld_addr = lda; ld_data = ldd; end
      else if (k == ld_k + 1) ld_en = 1'b0;
      if (k == rst_k) rst = 1'b1;
      else if (k == rst_k + 1) rst = 1'b0;
    end
    req = 1'b0;
  endtask

  task automatic preload(input logic [11:0] a, input logic [63:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; addr = '0; len = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid); end
    n_tests++; if (finish !== 1'b0) begin n_fail++; $display("FAIL reset_finish got %b exp 0", finish); end
    n_tests++; if (data !== 64'd0) begin n_fail++; $display("FAIL reset_data got %h exp 0", data); end
`ifdef RD_BURST_ADDR_CHK_EN
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
`endif
  endtask

  // Words 0..7 = 0x10..0x17; burst addr 0 len 4, addr/len scrambled after acceptance.
  task automatic test_basic;
    for (int i = 0; i < 8; i++) preload(12'(i), 64'(16 + i));
    run_burst(32'h0, 8'd4, 0, 32'h38, 8'd1, 6, -1, '0, '0, -1, 10);
    n_tests++; if (vcnt !== 4) begin n_fail++; $display("FAIL basic_vcnt got %0d exp 4", vcnt); end
    n_tests++; if (first_vk !== 2 || last_vk !== 5) begin n_fail++; $display("FAIL basic_vwin got %0d..%0d exp 2..5", first_vk, last_vk); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (vw[i] !== 64'(16 + i)) begin n_fail++; $display("FAIL basic_word%0d got %h exp %h", i, vw[i], 64'(16 + i)); end
    end
    n_tests++; if (fcnt !== 1 || fk0 !== 6) begin n_fail++; $display("FAIL basic_finish got cnt %0d at %0d exp 1 at 6", fcnt, fk0); end
    n_tests++; if (bad_idle !== 0) begin n_fail++; $display("FAIL basic_idle_data got %0d nonzero exp 0", bad_idle); end
  endtask

  // Request held across finish; address changed during GAP; exactly two bursts.
  task automatic test_held_req;
    run_burst(32'h0, 8'd4, 6, 32'h20, 8'd4, 14, -1, '0, '0, -1, 18);
    n_tests++; if (fcnt !== 2 || fk0 !== 6 || fk1 !== 14) begin n_fail++; $display("FAIL held_finish got cnt %0d at %0d,%0d exp 2 at 6,14", fcnt, fk0, fk1); end
    n_tests++; if (vcnt !== 8 || last_vk !== 13) begin n_fail++; $display("FAIL held_vcnt got %0d last %0d exp 8 last 13", vcnt, last_vk); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (vw[4 + i] !== 64'(20 + i)) begin n_fail++; $display("FAIL held_word%0d got %h exp %h", i, vw[4 + i], 64'(20 + i)); end
    end
  endtask

  // len=0 held: finish at 1, re-accepted at 3 -> second finish at 4.
  task automatic test_zero_len;
    run_burst(32'h8, 8'd0, -1, '0, '0, 4, -1, '0, '0, -1, 8);
    n_tests++; if (vcnt !== 0) begin n_fail++; $display("FAIL zlen_vcnt got %0d exp 0", vcnt); end
    n_tests++; if (fk0 !== 1) begin n_fail++; $display("FAIL zlen_finish got %0d exp 1", fk0); end
    n_tests++; if (fcnt !== 2 || fk1 !== 4) begin n_fail++; $display("FAIL zlen_reaccept got cnt %0d at %0d exp 2 at 4", fcnt, fk1); end
  endtask

  // Start at word 4094, len 4: wraps (default) or returns zeros with sticky error.
  task automatic test_wrap;
    logic [63:0] exp_w [0:3];
    preload(12'd4094, 64'hF0E);
    preload(12'd4095, 64'hF0F);
`ifdef RD_BURST_ADDR_CHK_EN
    exp_w[0] = 64'h0; exp_w[1] = 64'h0; exp_w[2] = 64'h0; exp_w[3] = 64'h0;
`else
    exp_w[0] = 64'hF0E; exp_w[1] = 64'hF0F; exp_w[2] = 64'h10; exp_w[3] = 64'h11;
`endif
    run_burst(32'h7FF0, 8'd4, -1, '0, '0, 6, -1, '0, '0, -1, 10);
    n_tests++; if (vcnt !== 4 || first_vk !== 2) begin n_fail++; $display("FAIL wrap_vcnt got %0d from %0d exp 4 from 2", vcnt, first_vk); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (vw[i] !== exp_w[i]) begin n_fail++; $display("FAIL wrap_word%0d got %h exp %h", i, vw[i], exp_w[i]); end
    end
    n_tests++; if (fk0 !== 6) begin n_fail++; $display("FAIL wrap_finish got %0d exp 6", fk0); end
`ifdef RD_BURST_ADDR_CHK_EN
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL wrap_err got %b exp 1", err); end
`endif
  endtask

  // Preload write to word 0 on the same edge that reads it: old data returned.
  task automatic test_read_first;
    run_burst(32'h0, 8'd2, -1, '0, '0, 4, 0, 12'd0, 64'h99, -1, 8);
    n_tests++; if (vw[0] !== 64'h10 || vw[1] !== 64'h11) begin n_fail++; $display("FAIL rfirst_old got %h,%h exp 10,11", vw[0], vw[1]); end
    run_burst(32'h0, 8'd1, -1, '0, '0, 3, -1, '0, '0, -1, 7);
    n_tests++; if (vcnt !== 1 || vw[0] !== 64'h99) begin n_fail++; $display("FAIL rfirst_new got %0d words %h exp 1 word 99", vcnt, vw[0]); end
  endtask

  // Reset applied after edge 3 of a len=8 burst: burst abandoned, next one normal.
  task automatic test_reset_mid;
    run_burst(32'h0, 8'd8, -1, '0, '0, 3, -1, '0, '0, 3, 16);
    n_tests++; if (vcnt !== 2 || last_vk !== 3) begin n_fail++; $display("FAIL rmid_valid got %0d last %0d exp 2 last 3", vcnt, last_vk); end
    n_tests++; if (fcnt !== 0) begin n_fail++; $display("FAIL rmid_finish got %0d exp 0", fcnt); end
`ifdef RD_BURST_ADDR_CHK_EN
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rmid_err got %b exp 0", err); end
`endif
    run_burst(32'h8, 8'd2, -1, '0, '0, 4, -1, '0, '0, -1, 8);
    n_tests++; if (vcnt !== 2 || vw[0] !== 64'h11 || vw[1] !== 64'h12) begin n_fail++; $display("FAIL rmid_next got %0d words %h,%h exp 2 words 11,12", vcnt, vw[0], vw[1]); end
    n_tests++; if (fk0 !== 4) begin n_fail++; $display("FAIL rmid_next_finish got %0d exp 4", fk0); end
  endtask

  // Maximum length 255: counter must not overflow.
  task automatic test_max_len;
    run_burst(32'h0, 8'd255, -1, '0, '0, 257, -1, '0, '0, -1, 262);
    n_tests++; if (vcnt !== 255 || first_vk !== 2 || last_vk !== 256) begin n_fail++; $display("FAIL maxlen_valid got %0d %0d..%0d exp 255 2..256", vcnt, first_vk, last_vk); end
    n_tests++; if (fcnt !== 1 || fk0 !== 257) begin n_fail++; $display("FAIL maxlen_finish got cnt %0d at %0d exp 1 at 257", fcnt, fk0); end
    n_tests++; if (vw[0] !== 64'h99 || vw[7] !== 64'h17) begin n_fail++; $display("FAIL maxlen_words got %h,%h exp 99,17", vw[0], vw[7]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held_req();
    test_zero_len();
    test_wrap();
    test_read_first();
    test_reset_mid();
    test_max_len();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_rd_responder.md
BURST_RD_RESPONDER -- requirements
Module: burst_rd_responder

Interface
REQ-001 Parameter MEM_DEPTH, default 4096: on-chip word count; SHALL be a power of two.
REQ-002 Parameter MEM_AW, default $clog2(MEM_DEPTH): word-address width.
REQ-003 s_clk  input  1  sole clock; all logic SHALL be synchronous to its rising edge.
REQ-004 s_rst  input  1  reset; SHALL be synchronous and active-high.
REQ-005 rd_burst_req  input  1  read request from initiator; held high until finish.
REQ-006 rd_burst_addr  input  `ADDR_SIZE  byte start address.
REQ-007 rd_burst_len  input  `LEN_WIDTH  burst length in words.
REQ-008 rd_burst_data  output  `DATA_WIDTH  returned word.
REQ-009 rd_burst_valid  output  1  rd_burst_data qualifier.
REQ-010 rd_burst_finish  output  1  one-cycle end-of-burst pulse.
REQ-011 ld_wr_en  input  1  preload write strobe.
REQ-012 ld_wr_addr  input  MEM_AW  preload word address.
REQ-013 ld_wr_data  input  `DATA_WIDTH  preload data.

Function
REQ-014 FSM states: IDLE, READ, FIN, GAP; reset state IDLE.
REQ-015 IDLE, rd_burst_req=1 at edge T: latch word index = rd_burst_addr >> $clog2(`DATA_WIDTH/8) and length; go to READ (len>0) or FIN (len=0).
REQ-016 READ: one RAM read per cycle at consecutive word addresses, first at T+1; leave after issuing len reads.
REQ-017 RAM read latency SHALL be 1 cycle; rd_burst_valid high on exactly len contiguous cycles, T+2 through T+1+len.
REQ-018 rd_burst_finish SHALL pulse once at T+2+len (cycle after last valid); T+1 when len=0.
REQ-019 GAP: one cycle after FIN in which rd_burst_req is ignored, then IDLE (prevents re-accepting the held request).
REQ-020 rd_burst_addr/len changes after acceptance SHALL NOT affect an accepted burst.
REQ-021 Word address SHALL wrap modulo MEM_DEPTH (macro off).
REQ-022 Preload write SHALL be accepted in any state; same-cycle read of the same word SHALL return old data (read-first).
REQ-023 rd_burst_data SHALL be zero whenever rd_burst_valid is low.
REQ-024 Length counter SHALL be `LEN_WIDTH+1 bits; maximum len SHALL complete without overflow.

Reset
REQ-025 On s_rst: state IDLE, rd_burst_valid=0, rd_burst_finish=0, rd_burst_data=0, counters 0; RAM contents need not be cleared.
REQ-026 Reset mid-burst SHALL abandon the burst; no further valid or finish for it.

Configuration
REQ-027 Macro RD_BURST_ADDR_CHK_EN defined: output rd_burst_err (1 bit) added; a burst with start word + len > MEM_DEPTH returns len zero words and sets rd_burst_err sticky until s_rst; timing unchanged.
REQ-028 Macro undefined: no rd_burst_err port, wrap per REQ-021.

Structure
REQ-029 Widths `DATA_WIDTH, `ADDR_SIZE, `LEN_WIDTH and FSM state encodings SHALL come from the shared hyper_para.v header.
REQ-030 Sub-module burst_rd_mem: simple dual-port synchronous RAM, one write port, one read port, 1-cycle latency, read-first.

Verification
REQ-031 Preload words 0..7 = 0x10..0x17; req addr=0x0, len=4 at T -> valid T+2..T+5 data 0x10..0x13, finish T+6.
REQ-032 Req held high across finish and reasserted cycle after GAP with addr=0x20, len=4 -> exactly two bursts, second returns 0x14..0x17.
REQ-033 len=0 at T -> no valid, finish at T+1, next acceptance no earlier than T+3.
REQ-034 Macro off, MEM_DEPTH=4096, addr=(4094<<3), len=4 -> words 4094,4095,0,1 in order.
REQ-035 s_rst asserted at T+3 of len=8 burst -> valid/finish low from T+4, IDLE, next req served normally.
REQ-036 Macro on, same as REQ-034 -> four zero words, finish at normal cycle, rd_burst_err=1 until s_rst.
